seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 262144, meaning sys_clk cycles per digit slot (legal range 2..2^24).
REQ-002 SHALL provide: sys_clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide: load_valid  input  1  new display value offered.
REQ-005 SHALL provide: load_ready  output  1  pending slot empty, offer can be taken.
REQ-006 SHALL provide: load_data  input  16  four hex nibbles; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
REQ-007 SHALL provide: load_dp  input  4  decimal-point enables, bit n = digit n, 1=lit.
REQ-008 SHALL provide: blank_lz  input  1  leading-zero blanking enable, sampled live.
REQ-009 SHALL provide: Segment_Sel  output  4  active-low digit select, one-hot-low.
REQ-010 SHALL provide: Segment_Out  output  8  active-low segments, [7]=dp, [6:0]=g..a.
REQ-011 SHALL provide: frame_done  output  1  one-cycle pulse at end of each full 4-digit scan.

Function
REQ-012 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is asserted in the cycle the count equals TICK_DIV-1.
REQ-013 Scan FSM states SHALL be BLANK, DIG0, DIG1, DIG2, DIG3; on tick: BLANK->DIG0, DIG0->DIG1, DIG1->DIG2, DIG2->DIG3, DIG3->DIG0; no transition without tick.
REQ-014 Segment_Sel SHALL be registered: BLANK=1111, DIG0=1110, DIG1=1101, DIG2=1011, DIG3=0111.
REQ-015 Segment_Out SHALL be registered and change on the same edge as Segment_Sel; BLANK state drives 8'hFF.
REQ-016 Nibble encoding ([6:0], dp off => [7]=1): 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=A0,B=83,C=C6,D=A1,E=86,F=8E; lit dp clears bit 7.
REQ-017 Two 20-bit registers SHALL exist: pending {dp,data} with valid flag, and display {dp,data}.
REQ-018 load_ready SHALL equal NOT pending-valid; transfer occurs on a rising edge with load_valid=1 and load_ready=1.
REQ-019 Accepted data SHALL NOT reach the display register mid-frame; commit occurs only on the DIG3->DIG0 tick, copying pending to display and clearing pending-valid.
REQ-020 Accept and DIG3->DIG0 tick in the same cycle with pending empty: data SHALL enter pending, no commit that frame.
REQ-021 load_ready SHALL be high in the cycle after a commit; back-to-back values are therefore displayed one per frame.
REQ-022 frame_done SHALL pulse for exactly one cycle, aligned with the DIG3->DIG0 edge, whether or not a commit occurred.
REQ-023 With blank_lz=1, digit n (n=3,2,1) SHALL show segments [6:0]=7F if its nibble and all higher nibbles are zero; its dp still follows load_dp; digit0 is never blanked.
REQ-024 Display value SHALL be taken from the display register only; load_data changes without a transfer SHALL have no visible effect.

Reset
REQ-025 Reset assertion SHALL immediately force: tick counter 0, state BLANK, Segment_Sel=1111, Segment_Out=FF, frame_done=0, pending-valid=0 (load_ready=1), display register 0 with dp 0.
REQ-026 Reset mid-frame or with pending data SHALL discard the pending value; first DIG0 follows TICK_DIV cycles after deassertion.

Verification (TICK_DIV=4)
REQ-027 Release reset, no loads -> Sel 1111/Out FF for 4 cycles, then 1110/C0, 1101/C0, 1011/C0, 0111/C0 each 4 cycles, frame_done pulse at DIG3->DIG0.
REQ-028 Load 16'h12AF, dp=0001 mid-DIG1 -> load_ready low next cycle; display unchanged until wrap, then DIG0=0E, DIG1=A0, DIG2=A4, DIG3=F9; load_ready high after commit.
REQ-029 Hold load_valid with 16'h0001 then 16'h0002 continuously -> first accepted, second stalls (ready low) until commit, shown one frame later.
REQ-030 blank_lz=1, display 16'h0070, dp=0100 -> DIG3=FF, DIG2=7F, DIG1=F8, DIG0=C0; blank_lz=0 -> DIG3=C0, DIG2=40.
REQ-031 Load accepted exactly in DIG3->DIG0 tick cycle -> no commit that frame; committed at next wrap.
REQ-032 Assert reset during DIG2 with pending data -> immediate Sel 1111/Out FF, load_ready=1; after release, zeros displayed, discarded value never appears.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// A tick divider paces the digit scan. New values go into a one-entry pending
// slot, and the display register picks them up only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned TICK_DIV = 262144
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic        blank_lz,
  output logic [3:0]  Segment_Sel,
  output logic [7:0]  Segment_Out,
  output logic        frame_done
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    BLANK,
    DIG0,
    DIG1,
    DIG2,
    DIG3
  } scan_state_t;

  scan_state_t   state, state_next;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          wrap;
  logic          commit;
  logic          accept;
  logic          pend_valid;
  logic [19:0]   pend_val;
  logic [19:0]   disp_val;
  logic [19:0]   disp_next;
  logic [3:0]    sel_next;
  logic [7:0]    out_next;

  // Seven-segment pattern for one hex nibble, active low, bits g..a.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h20;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick   = (tick_cnt == TICK_MAX);
  assign wrap   = tick && (state == DIG3);
  assign commit = wrap && pend_valid;
  assign accept = load_valid && !pend_valid;
  assign load_ready = !pend_valid;
  assign disp_next  = commit ? pend_val : disp_val;

  // Digit-slot divider: count 0..TICK_DIV-1, then wrap.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Scan state register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= BLANK;
    else       state <= state_next;
  end

  // Scan sequencing: advance one digit per tick, DIG3 loops back to DIG0.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        BLANK:   state_next = DIG0;
        DIG0:    state_next = DIG1;
        DIG1:    state_next = DIG2;
        DIG2:    state_next = DIG3;
        DIG3:    state_next = DIG0;
        default: state_next = BLANK;
      endcase
    end
  end

  // Pending slot: a commit empties it, so it cannot also accept in that cycle.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_val   <= '0;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_val   <= {load_dp, load_data};
    end
  end

  // Display register is updated only at the frame wrap.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)       disp_val <= '0;
    else if (commit) disp_val <= pend_val;
  end

  // Decode for the upcoming state. The outputs are registered, so they use
  // disp_next: a freshly committed value then appears together with DIG0.
  always_comb begin
    sel_next = '1;
    out_next = '1;
    case (state_next)
      DIG0: begin
        sel_next = 4'b1110;
        out_next = {~disp_next[16], hex7(disp_next[3:0])};
      end
      DIG1: begin
        sel_next = 4'b1101;
        out_next = {~disp_next[17],
                    (blank_lz && disp_next[15:4] == '0) ? 7'h7F : hex7(disp_next[7:4])};
      end
      DIG2: begin
        sel_next = 4'b1011;
        out_next = {~disp_next[18],
                    (blank_lz && disp_next[15:8] == '0) ? 7'h7F : hex7(disp_next[11:8])};
      end
      DIG3: begin
        sel_next = 4'b0111;
        out_next = {~disp_next[19],
                    (blank_lz && disp_next[15:12] == '0) ? 7'h7F : hex7(disp_next[15:12])};
      end
      default: begin
        sel_next = '1;
        out_next = '1;
      end
    endcase
  end

  // Output registers: select, segments and the frame pulse all change on one edge.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      Segment_Sel <= '1;
      Segment_Out <= '1;
      frame_done  <= 1'b0;
    end else begin
      Segment_Sel <= sel_next;
      Segment_Out <= out_next;
      frame_done  <= wrap;
    end
  end

endmodule
